// File: rtl/point_rotator_if.sv
// Operand and result handshake bundle for point_rotator.
interface point_rotator_if #(
  parameter int W  = 20,
  parameter int TW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x_in;
  logic [W-1:0]  y_in;
  logic [TW-1:0] theta_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  x_out;
  logic [W-1:0]  y_out;

  modport master (output in_valid, x_in, y_in, theta_in, out_ready,
                  input  in_ready, out_valid, x_out, y_out);
  modport slave  (input  in_valid, x_in, y_in, theta_in, out_ready,
                  output in_ready, out_valid, x_out, y_out);
endinterface

// File: rtl/point_rotator.sv
// Rotates (x,y) by theta degrees using one shared s20 multiplier over four cycles.
// Define ROTATOR_SAT_EN to clamp the final sums instead of letting them wrap.
module point_rotator #(
  parameter int W    = 20,
  parameter int TW   = 10,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            reset,
  point_rotator_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, REDUCE, MUL, ADD, OUT} state_e;

  localparam logic [TW-1:0] DEG360 = TW'(360);

  // floor(256*sin(d)) for d = 0..90; other quadrants fold onto this.
  localparam logic [8:0] SIN_Q [91] = '{
    9'd0,   9'd4,   9'd8,   9'd13,  9'd17,  9'd22,  9'd26,  9'd31,  9'd35,  9'd40,
    9'd44,  9'd48,  9'd53,  9'd57,  9'd61,  9'd66,  9'd70,  9'd74,  9'd79,  9'd83,
    9'd87,  9'd91,  9'd95,  9'd100, 9'd104, 9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
    9'd128, 9'd131, 9'd135, 9'd139, 9'd143, 9'd146, 9'd150, 9'd154, 9'd157, 9'd161,
    9'd164, 9'd167, 9'd171, 9'd174, 9'd177, 9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
    9'd196, 9'd198, 9'd201, 9'd204, 9'd207, 9'd209, 9'd212, 9'd214, 9'd217, 9'd219,
    9'd221, 9'd223, 9'd226, 9'd228, 9'd230, 9'd232, 9'd233, 9'd235, 9'd237, 9'd238,
    9'd240, 9'd242, 9'd243, 9'd244, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
    9'd252, 9'd252, 9'd253, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd255, 9'd255,
    9'd256
  };

  function automatic logic signed [W-1:0] sin_lut(input logic [8:0] a);
    logic [6:0]          m;
    logic                neg;
    logic signed [W-1:0] mag;
    m   = 7'(a);
    neg = 1'b0;
    if (a <= 9'd90)       m = 7'(a);
    else if (a <= 9'd180) m = 7'(9'd180 - a);
    else if (a <= 9'd270) begin m = 7'(a - 9'd180); neg = 1'b1; end
    else                  begin m = 7'(9'd360 - a); neg = 1'b1; end
    mag = {{(W-9){1'b0}}, SIN_Q[m]};
    return neg ? -mag : mag;
  endfunction

`ifdef ROTATOR_SAT_EN
  function automatic logic [W-1:0] sat(input logic [W:0] s);
    if (s[W] != s[W-1]) return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction
`endif

  state_e                state_q, state_d;
  logic signed [W-1:0]   x_q, y_q;
  logic [TW-1:0]         th_q;
  logic [1:0]            cnt_q;
  logic signed [W-1:0]   p_q [4];
  logic [W-1:0]          xo_q, yo_q;

  logic [8:0]            th9, th_c;
  logic signed [W-1:0]   sin_v, cos_v, mul_a, mul_b, mul_res;
  logic signed [2*W-1:0] prod;
  logic [W-1:0]          sum_x, sum_y;
  logic                  unused_prod;
  logic                  in_rdy, out_vld;

  // Reduced theta is always < 360 once MUL is reached, so 9 bits suffice.
  assign th9   = th_q[8:0];
  assign th_c  = (th9 < 9'd270) ? th9 + 9'd90 : th9 - 9'd270;
  assign sin_v = sin_lut(th9);
  assign cos_v = sin_lut(th_c);

  // Product order: x*cos, y*sin, x*sin, y*cos.
  assign mul_a   = cnt_q[0] ? y_q : x_q;
  assign mul_b   = (cnt_q == 2'd1 || cnt_q == 2'd2) ? sin_v : cos_v;
  assign prod    = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
  assign mul_res = {prod[2*W-1], prod[W+FRAC-2:FRAC]};
  assign unused_prod = ^{prod[2*W-2:W+FRAC-1], prod[FRAC-1:0]};

`ifdef ROTATOR_SAT_EN
  assign sum_x = sat({p_q[0][W-1], p_q[0]} - {p_q[1][W-1], p_q[1]});
  assign sum_y = sat({p_q[2][W-1], p_q[2]} + {p_q[3][W-1], p_q[3]});
`else
  assign sum_x = p_q[0] - p_q[1];
  assign sum_y = p_q[2] + p_q[3];
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)    state_d = REDUCE;
      REDUCE:  if (th_q < DEG360)   state_d = MUL;
      MUL:     if (cnt_q == 2'd3)   state_d = ADD;
      ADD:                          state_d = OUT;
      OUT:     if (bus.out_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    in_rdy  = (state_q == IDLE);
    out_vld = (state_q == OUT);
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.x_out     = xo_q;
  assign bus.y_out     = yo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      th_q  <= '0;
      cnt_q <= '0;
      p_q   <= '{default: '0};
      xo_q  <= '0;
      yo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          x_q   <= bus.x_in;
          y_q   <= bus.y_in;
          th_q  <= bus.theta_in;
          cnt_q <= '0;
        end
        REDUCE: if (th_q >= DEG360) th_q <= th_q - DEG360;
        MUL: begin
          p_q[cnt_q] <= mul_res;
          cnt_q      <= cnt_q + 2'd1;
        end
        ADD: begin
          xo_q <= sum_x;
          yo_q <= sum_y;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_point_rotator.sv
// Randomized and directed checks of point_rotator against a trig/arithmetic reference model.
module tb_point_rotator;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  point_rotator_if bus();
  point_rotator dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  localparam real PI = 3.14159265358979;

  // Table value: 256*sin/cos truncated toward zero.
  function automatic int trig(input int deg, input bit is_cos);
    real v;
    v = 256.0 * (is_cos ? $cos(deg * PI / 180.0) : $sin(deg * PI / 180.0));
    if (v >= 0.0) return int'($floor(v + 1.0e-6));
    return -int'($floor(-v + 1.0e-6));
  endfunction

  // floor(a*t/256), magnitude bits wrapped modulo 2^19, sign of the full product kept.
  function automatic int mul_rule(input int a, input int t);
    longint p, q, r;
    p = longint'(a) * longint'(t);
    q = p >>> 8;
    r = q & 64'sh7FFFF;
    return (p < 0) ? int'(r - 524288) : int'(r);
  endfunction

  function automatic logic [19:0] fit(input int s);
`ifdef ROTATOR_SAT_EN
    if (s > 524287)  return 20'h7FFFF;
    if (s < -524288) return 20'h80000;
`endif
    return 20'(s);
  endfunction

  task automatic model(input logic [19:0] x, input logic [19:0] y, input int th,
                       output logic [19:0] ex, output logic [19:0] ey);
    int r, c, s, xi, yi;
    r  = th % 360;
    c  = trig(r, 1'b1);
    s  = trig(r, 1'b0);
    xi = int'($signed(x));
    yi = int'($signed(y));
    ex = fit(mul_rule(xi, c) - mul_rule(yi, s));
    ey = fit(mul_rule(xi, s) + mul_rule(yi, c));
  endtask

  // Issues one transaction; lat counts edges from accept until out_valid is seen.
  task automatic run_txn(input logic [19:0] x, input logic [19:0] y, input int th, input int stall,
                         output logic [19:0] rx, output logic [19:0] ry, output int lat);
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin @(posedge clk); #1; g++; end
    bus.in_valid = 1'b1; bus.x_in = x; bus.y_in = y; bus.theta_in = 10'(th);
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.x_in = 20'($urandom); bus.y_in = 20'($urandom);
    bus.theta_in = 10'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    repeat (stall) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    rx = bus.x_out; ry = bus.y_out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.x_in = '0; bus.y_in = '0; bus.theta_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.x_out !== 20'h0) begin n_bad++; $display("FAIL reset_x_out: got %h want 0", bus.x_out); end
    n_cmp++; if (bus.y_out !== 20'h0) begin n_bad++; $display("FAIL reset_y_out: got %h want 0", bus.y_out); end
  endtask

  task automatic test_directed(input string nm, input logic [19:0] x, input logic [19:0] y, input int th,
                               input logic [19:0] ex, input logic [19:0] ey, input int elat);
    logic [19:0] rx, ry;
    int lat;
    run_txn(x, y, th, 0, rx, ry, lat);
    n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, elat); end
    n_cmp++; if (rx !== ex) begin n_bad++; $display("FAIL %s_x: got %h want %h", nm, rx, ex); end
    n_cmp++; if (ry !== ey) begin n_bad++; $display("FAIL %s_y: got %h want %h", nm, ry, ey); end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_bad++; $display("FAIL %s_release: got valid=%b ready=%b want 0/1", nm, bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_overflow;
`ifdef ROTATOR_SAT_EN
    test_directed("overflow", 20'h7FF00, 20'h80100, 45, 20'h7FFFF, 20'h00000, 6);
`else
    test_directed("overflow", 20'h7FF00, 20'h80100, 45, 20'hB4E96, 20'h00000, 6);
`endif
  endtask

  task automatic test_backpressure;
    logic [19:0] hx, hy;
    int g, bad;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.x_in = 20'h00100; bus.y_in = 20'h0; bus.theta_in = 10'd90;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    g = 0;
    while (!bus.out_valid && g < 30) begin @(posedge clk); #1; g++; end
    hx = bus.x_out; hy = bus.y_out;
    n_cmp++; if (hx !== 20'h0 || hy !== 20'h00100) begin n_bad++; $display("FAIL bp_data: got %h/%h want 00000/00100", hx, hy); end
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.x_out !== hx || bus.y_out !== hy) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [19:0] xs [3], ys [3], qx [$], qy [$], ex, ey;
    int ts [3], acc, got, bad;
    logic a, h;
    for (int i = 0; i < 3; i++) begin xs[i] = 20'($urandom); ys[i] = 20'($urandom); ts[i] = $urandom_range(0, 1023); end
    acc = 0; got = 0; bad = 0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.x_in = xs[0]; bus.y_in = ys[0]; bus.theta_in = 10'(ts[0]);
    for (int c = 0; c < 80; c++) begin
      a = bus.in_valid && bus.in_ready;
      h = bus.out_valid && bus.out_ready;
      if (h) begin
        got++;
        if (qx.size() == 0) bad++;
        else begin
          ex = qx.pop_front(); ey = qy.pop_front();
          if (bus.x_out !== ex || bus.y_out !== ey) begin
            bad++; $display("FAIL b2b_data: got %h/%h want %h/%h", bus.x_out, bus.y_out, ex, ey);
          end
        end
      end
      @(posedge clk); #1;
      if (a) begin
        model(bus.x_in, bus.y_in, int'(bus.theta_in), ex, ey);
        qx.push_back(ex); qy.push_back(ey);
        acc++;
        if (acc < 3) begin bus.x_in = xs[acc]; bus.y_in = ys[acc]; bus.theta_in = 10'(ts[acc]); end
        else bus.in_valid = 1'b0;
      end
    end
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
    n_cmp++; if (got != 3) begin n_bad++; $display("FAIL b2b_results: got %0d want 3", got); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_check: got %0d bad results want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int seen;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.x_in = 20'h00100; bus.y_in = 20'h0; bus.theta_in = 10'd90;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_hs: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    n_cmp++; if (bus.x_out !== 20'h0 || bus.y_out !== 20'h0)
      begin n_bad++; $display("FAIL rstmid_out: got %h/%h want 0/0", bus.x_out, bus.y_out); end
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstmid_ghost: got %0d valid cycles want 0", seen); end
    test_directed("rstmid_after", 20'h00100, 20'h0, 90, 20'h00000, 20'h00100, 6);
  endtask

  task automatic test_random;
    logic [19:0] x, y, rx, ry, ex, ey;
    int th, lat, bad;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      x = 20'($urandom); y = 20'($urandom); th = $urandom_range(0, 1023);
      if (i % 3 == 0) begin x = 20'($urandom_range(0, 4095)); y = -20'($urandom_range(0, 4095)); end
      model(x, y, th, ex, ey);
      run_txn(x, y, th, $urandom_range(0, 3), rx, ry, lat);
      n_cmp++;
      if (rx !== ex || ry !== ey || lat != 6 + th / 360) begin
        n_bad++;
        $display("FAIL rand_%0d: x=%h y=%h th=%0d got %h/%h lat %0d want %h/%h lat %0d",
                 i, x, y, th, rx, ry, lat, ex, ey, 6 + th / 360);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed("basic",    20'h00100, 20'h00000, 90,  20'h00000, 20'h00100, 6);
    test_directed("half",     20'h00100, 20'h00000, 180, 20'hFFF00, 20'h00000, 6);
    test_directed("zero",     20'h00380, 20'hFFE00, 0,   20'h00380, 20'hFFE00, 6);
    test_directed("red400",   20'h00100, 20'h00000, 400, 20'h000C4, 20'h000A4, 7);
    test_directed("red760",   20'h00100, 20'h00000, 760, 20'h000C4, 20'h000A4, 8);
    test_directed("red360",   20'h00100, 20'h00000, 360, 20'h00100, 20'h00000, 7);
    test_directed("red1023",  20'h00100, 20'h00000, 1023, 20'h0008B, 20'hFFF2A, 8);
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/point_rotator.md
Name: point_rotator

Overview:
- Sequential stage directly downstream of the sine and cosine lookup tables.
- Accepts a 2-D point (x, y) and an angle theta in whole degrees, and returns the rotated point:
  - x' = x*cos(theta) - y*sin(theta)
  - y' = x*sin(theta) + y*cos(theta)
- Uses a single shared s20 fixed-point multiplier over four cycles. Feeds the display/vector stage through a valid/ready handshake.

Parameters:
- W, 20, data width; signed fixed point: 1 sign bit, 11 integer bits, 8 fraction bits (1.0 = 256).
- TW, 10, theta width, unsigned degrees.
- FRAC, 8, fraction bits; fixes product alignment.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand strobe.
- in_ready  out  1  block can accept operands.
- x_in  in  W  signed x.
- y_in  in  W  signed y.
- theta_in  in  TW  angle, 0..1023 degrees.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- x_out  out  W  rotated x.
- y_out  out  W  rotated y.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; in_ready=1; out_valid=0; x_out=0; y_out=0; all internal registers cleared. Reset asserted mid-operation aborts the transaction and drops the result; no out_valid follows.
- in_ready is 1 only in IDLE.
- Accept occurs at a rising edge with in_valid&&in_ready. On accept, x_in, y_in and theta_in are registered; later input changes are ignored.
- FSM states IDLE -> REDUCE -> MUL -> ADD -> OUT -> IDLE.
  - REDUCE: if theta>=360, theta-=360 and stay; else go to MUL. Always at least 1 cycle; 1023 needs 2 subtractions, so 3 cycles maximum.
  - MUL: 2-bit counter, 4 cycles, one product per cycle in order p0=x*cos, p1=y*sin, p2=x*sin, p3=y*cos. Reduced theta drives the sine/cosine tables combinationally.
  - ADD: x_out=p0-p1, y_out=p2+p3, each computed in W bits.
  - OUT: out_valid=1. x_out and y_out are held stable while out_ready=0. On out_valid&&out_ready, go to IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
- Latency:
  - theta<360: accept at edge k -> out_valid high after edge k+6.
  - Each extra subtraction adds 1 cycle (theta 400 -> k+7; theta 800 -> k+8).
- Throughput: no overlap; one transaction in flight.
- Multiply rule: full 40-bit signed product; result = {prod[39], prod[26:8]}, which truncates toward negative infinity. Overflow beyond bit 26 is discarded silently.
- Sum overflow: without the optional feature, x_out and y_out wrap modulo 2^20.
- Table range: theta=360 never reaches the tables; REDUCE maps it to 0.
- in_valid asserted while busy is ignored; no accept occurs.

Optional Feature:
- Macro ROTATOR_SAT_EN.
- When defined, ADD computes 21-bit sums and clamps them to [0x80000, 0x7FFFF]: max is 2047.996, min is -2048.0.
- When undefined, sums wrap in 20 bits.
- Latency is identical in both cases.

Test Plan:
- Basic rotation: reset, then x=256, y=0, theta=90 -> x_out=0, y_out=256 (0x00100); out_valid high exactly 6 cycles after accept.
- Half turn: x=256, y=0, theta=180 -> x_out=0xFFF00 (-256), y_out=0. Then theta=0, x=0x00380, y=0xFFE00 -> outputs equal inputs.
- Angle reduction: theta=400, x=256, y=0 -> x_out=196 (0x000C4), y_out=164 (0x000A4) at latency 7. theta=760, same x and y -> same result at latency 8.
- Backpressure: out_ready=0 for 10 cycles -> out_valid stays 1 with stable data and in_ready=0. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle. Back-to-back transactions with in_valid held high are each accepted exactly once.
- Overflow: x=0x7FF00, y=0x80100, theta=45 (sin=cos=181) -> y_out=0.
  - Without ROTATOR_SAT_EN: x_out=0xB4E96.
  - With ROTATOR_SAT_EN: x_out=0x7FFFF.
- Reset mid-operation: reset pulsed during the MUL state -> next cycle in_ready=1, out_valid=0, outputs 0. A following transaction (x=256, y=0, theta=90) still gives x_out=0, y_out=256.
